// File: rtl/brick_collide_scan_if.sv
// brick_collide_scan_if
// Groups the frame request, latched-input and result signals of the
// brick collision scanner.
//   frame_tick      : one-cycle scan request
//   ball_x, ball_y  : ball box top-left corner (pixels, unsigned)
//   alive           : brick alive flags, bit i = brick i
//   collide         : per-brick hit flags of the last completed scan
//   bounce_x/_y     : one-cycle velocity reflection pulses
//   done            : one-cycle scan-complete pulse
//   busy            : scanner is in SCAN or REPORT
// The master drives requests and inputs; the slave (the scanner) drives results.
interface brick_collide_scan_if;
  logic        frame_tick;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [14:0] alive;
  logic [14:0] collide;
  logic        bounce_x;
  logic        bounce_y;
  logic        done;
  logic        busy;

  modport master (
    output frame_tick, ball_x, ball_y, alive,
    input  collide, bounce_x, bounce_y, done, busy
  );

  modport slave (
    input  frame_tick, ball_x, ball_y, alive,
    output collide, bounce_x, bounce_y, done, busy
  );
endinterface

// File: rtl/brick_collide_scan.sv
// brick_collide_scan
// On a frame tick, latches the ball position and brick alive flags, then
// walks the 3x5 brick grid one brick per cycle, accumulating which live
// bricks the ball box overlaps and which axis the first hit should reflect.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : brick_collide_scan_if.slave (frame_tick, ball_x, ball_y, alive in;
//          collide, bounce_x, bounce_y, done, busy out)
//
// state  | meaning
// IDLE   | waiting for frame_tick
// SCAN   | testing brick idx (0..14), one per cycle
// REPORT | publishing collide / bounce / done on exit
module brick_collide_scan #(
  parameter int X0      = 40,
  parameter int Y0      = 40,
  parameter int BRICK_W = 100,
  parameter int BRICK_H = 20,
  parameter int GAP_X   = 12,
  parameter int GAP_Y   = 10,
  parameter int BALL    = 8
) (
  input logic clk,
  input logic rst,
  brick_collide_scan_if.slave bus
);

  localparam logic [10:0] X0_W     = 11'(X0);
  localparam logic [10:0] Y0_W     = 11'(Y0);
  localparam logic [10:0] BW_W     = 11'(BRICK_W);
  localparam logic [10:0] BH_W     = 11'(BRICK_H);
  localparam logic [10:0] BALL_W   = 11'(BALL);
  localparam logic [10:0] COL_STEP = 11'(BRICK_W + GAP_X);
  localparam logic [10:0] ROW_STEP = 11'(BRICK_H + GAP_Y);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t state, state_nxt;

  logic        start, step, report;
  logic [9:0]  bx_q, by_q;
  logic [14:0] alive_q, acc;
  logic [3:0]  idx;
  logic [2:0]  col;
  logic [1:0]  row;
  logic [10:0] brx, bry;
  logic        hit_seen, axis_x, axis_y;

  logic [10:0]        ball_l, ball_r, ball_t, ball_b;
  logic [10:0]        brick_r, brick_b;
  logic [10:0]        lo_x, hi_x, lo_y, hi_y;
  logic signed [10:0] ox, oy;
  logic               hit;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.frame_tick) state_nxt = SCAN;
      SCAN:    if (idx == 4'd14)   state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded controls
  always_comb begin
    start    = (state == IDLE) && bus.frame_tick;
    step     = (state == SCAN);
    report   = (state == REPORT);
    bus.busy = (state != IDLE);
  end

  // Overlap of ball box and current brick. Right/bottom ends use 11 bits so
  // a ball near 1023 does not wrap; the difference always fits signed 11 bits.
  always_comb begin
    ball_l  = {1'b0, bx_q};
    ball_t  = {1'b0, by_q};
    ball_r  = ball_l + BALL_W;
    ball_b  = ball_t + BALL_W;
    brick_r = brx + BW_W;
    brick_b = bry + BH_W;
    lo_x    = (ball_l > brx)     ? ball_l : brx;
    hi_x    = (ball_r < brick_r) ? ball_r : brick_r;
    lo_y    = (ball_t > bry)     ? ball_t : bry;
    hi_y    = (ball_b < brick_b) ? ball_b : brick_b;
    ox      = $signed(hi_x - lo_x);
    oy      = $signed(hi_y - lo_y);
    hit     = step && alive_q[idx] && (ox > 11'sd0) && (oy > 11'sd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_q         <= '0;
      by_q         <= '0;
      alive_q      <= '0;
      acc          <= '0;
      idx          <= '0;
      col          <= '0;
      row          <= '0;
      brx          <= '0;
      bry          <= '0;
      hit_seen     <= 1'b0;
      axis_x       <= 1'b0;
      axis_y       <= 1'b0;
      bus.collide  <= '0;
      bus.done     <= 1'b0;
      bus.bounce_x <= 1'b0;
      bus.bounce_y <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.bounce_x <= 1'b0;
      bus.bounce_y <= 1'b0;
      if (start) begin
        bx_q     <= bus.ball_x;
        by_q     <= bus.ball_y;
        alive_q  <= bus.alive;
        acc      <= '0;
        idx      <= '0;
        col      <= '0;
        row      <= '0;
        brx      <= X0_W;
        bry      <= Y0_W;
        hit_seen <= 1'b0;
        axis_x   <= 1'b0;
        axis_y   <= 1'b0;
      end
      if (step) begin
        if (hit) begin
          acc[idx] <= 1'b1;
          // only the lowest-index hit decides the reflection axis
          if (!hit_seen) begin
            hit_seen <= 1'b1;
            axis_x   <= (ox <= oy);
            axis_y   <= (oy <= ox);
          end
        end
        idx <= idx + 4'd1;
        if (col == 3'd4) begin
          col <= '0;
          brx <= X0_W;
          row <= row + 2'd1;
          bry <= bry + ROW_STEP;
        end else begin
          col <= col + 3'd1;
          brx <= brx + COL_STEP;
        end
      end
      if (report) begin
        bus.collide  <= acc;
        bus.done     <= 1'b1;
        bus.bounce_x <= axis_x;
        bus.bounce_y <= axis_y;
      end
    end
  end

endmodule

// File: tb/tb_brick_collide_scan.sv
// tb_brick_collide_scan
// Self-checking bench for brick_collide_scan: directed cases with constant
// expectations plus randomized scans checked against a geometric reference.
module tb_brick_collide_scan;
  localparam int X0 = 40, Y0 = 40, BRICK_W = 100, BRICK_H = 20;
  localparam int GAP_X = 12, GAP_Y = 10, BALL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  brick_collide_scan_if bus_if();
  brick_collide_scan dut (.clk(clk), .rst(rst), .bus(bus_if));

  int passed = 0;
  int total  = 0;

  // Reference: direct geometry per brick, index order decides the axis.
  function automatic void ref_scan(input int bx, input int by, input logic [14:0] al,
                                   output logic [14:0] col, output logic ex, output logic ey);
    bit first = 1'b1;
    col = '0; ex = 1'b0; ey = 1'b0;
    for (int i = 0; i < 15; i++) begin
      int r, c, lx, ty, ox, oy;
      r  = i / 5;
      c  = i % 5;
      lx = X0 + c * (BRICK_W + GAP_X);
      ty = Y0 + r * (BRICK_H + GAP_Y);
      ox = ((bx + BALL < lx + BRICK_W) ? bx + BALL : lx + BRICK_W) - ((bx > lx) ? bx : lx);
      oy = ((by + BALL < ty + BRICK_H) ? by + BALL : ty + BRICK_H) - ((by > ty) ? by : ty);
      if (ox > 0 && oy > 0 && al[i]) begin
        col[i] = 1'b1;
        if (first) begin
          first = 1'b0;
          ex = (ox <= oy);
          ey = (oy <= ox);
        end
      end
    end
  endfunction

  // Issues one tick and observes the whole scan window (stimulus/observation only).
  task automatic do_scan(input int bx, input int by, input logic [14:0] al, input int extra_k,
                         output int lat, output logic [14:0] col_done, output logic bxd,
                         output logic byd, output int ndone, output int nbx, output int nby,
                         output logic [14:0] col_pre, output logic [14:0] col_late,
                         output int busy_bad);
    lat = -1; col_done = 'x; bxd = 1'bx; byd = 1'bx;
    ndone = 0; nbx = 0; nby = 0; busy_bad = 0; col_pre = '0;
    @(negedge clk);
    bus_if.ball_x = bx[9:0];
    bus_if.ball_y = by[9:0];
    bus_if.alive  = al;
    bus_if.frame_tick = 1'b1;
    @(negedge clk);
    bus_if.frame_tick = 1'b0;
    for (int k = 0; k < 26; k++) begin
      if (k == 3) begin
        bus_if.ball_x = 10'($urandom());
        bus_if.ball_y = 10'($urandom());
        bus_if.alive  = 15'($urandom());
      end
      bus_if.frame_tick = (k == extra_k);
      if (k == 8) col_pre = bus_if.collide;
      if (bus_if.done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat = k; col_done = bus_if.collide;
          bxd = bus_if.bounce_x; byd = bus_if.bounce_y;
        end
      end
      if (bus_if.bounce_x === 1'b1) nbx++;
      if (bus_if.bounce_y === 1'b1) nby++;
      if (bus_if.busy !== (k < 16)) busy_bad++;
      @(negedge clk);
    end
    bus_if.frame_tick = 1'b0;
    col_late = bus_if.collide;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.frame_tick = 1'b0;
    bus_if.ball_x = '0; bus_if.ball_y = '0; bus_if.alive = '0;
    repeat (3) @(negedge clk);
    total++; if (bus_if.collide !== 15'h0) $display("FAIL reset_collide got %h want 0", bus_if.collide); else passed++;
    total++; if (bus_if.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus_if.done); else passed++;
    total++; if ({bus_if.bounce_x, bus_if.bounce_y} !== 2'b00) $display("FAIL reset_bounce got %b%b want 00", bus_if.bounce_x, bus_if.bounce_y); else passed++;
    total++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus_if.busy); else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) $display("FAIL post_reset_idle busy %b done %b want 0 0", bus_if.busy, bus_if.done); else passed++;
  endtask

  task automatic test_directed();
    int bxs[5] = '{80, 136, 136, 142, 132};
    int bys[5] = '{55, 45, 56, 45, 60};
    logic [14:0] ecol[5] = '{15'h0001, 15'h0001, 15'h0001, 15'h0000, 15'h0000};
    logic ex[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic ey[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat, nd, nbx, nby, bb;
    logic [14:0] cd, cp, cl;
    logic bxd, byd;
    for (int i = 0; i < 5; i++) begin
      do_scan(bxs[i], bys[i], 15'h7FFF, -1, lat, cd, bxd, byd, nd, nbx, nby, cp, cl, bb);
      total++; if (lat !== 16) $display("FAIL dir%0d_latency got %0d want 16", i, lat); else passed++;
      total++; if (cd !== ecol[i]) $display("FAIL dir%0d_collide got %h want %h", i, cd, ecol[i]); else passed++;
      total++; if (bxd !== ex[i] || byd !== ey[i]) $display("FAIL dir%0d_bounce got x%b y%b want x%b y%b", i, bxd, byd, ex[i], ey[i]); else passed++;
      total++; if (nd !== 1 || nbx !== int'(ex[i]) || nby !== int'(ey[i])) $display("FAIL dir%0d_pulse_width done %0d bx %0d by %0d want 1 %0d %0d", i, nd, nbx, nby, ex[i], ey[i]); else passed++;
      total++; if (cl !== ecol[i]) $display("FAIL dir%0d_collide_hold got %h want %h", i, cl, ecol[i]); else passed++;
      total++; if (bb !== 0) $display("FAIL dir%0d_busy got %0d bad cycles want 0", i, bb); else passed++;
    end
  endtask

  task automatic test_alive_mask();
    int lat, nd, nbx, nby, bb;
    logic [14:0] cd, cp, cl;
    logic bxd, byd;
    do_scan(80, 55, 15'h7FFF, -1, lat, cd, bxd, byd, nd, nbx, nby, cp, cl, bb);
    do_scan(80, 55, 15'h7FFE, -1, lat, cd, bxd, byd, nd, nbx, nby, cp, cl, bb);
    total++; if (cp !== 15'h0001) $display("FAIL mask_prev_hold got %h want 0001", cp); else passed++;
    total++; if (cd !== 15'h0000) $display("FAIL mask_collide got %h want 0000", cd); else passed++;
    total++; if (nbx !== 0 || nby !== 0) $display("FAIL mask_bounce got bx %0d by %0d want 0 0", nbx, nby); else passed++;
    total++; if (nd !== 1 || lat !== 16) $display("FAIL mask_done got %0d pulses lat %0d want 1 16", nd, lat); else passed++;
  endtask

  task automatic test_tick_while_busy();
    int lat, nd, nbx, nby, bb;
    logic [14:0] cd, cp, cl;
    logic bxd, byd;
    do_scan(136, 45, 15'h7FFF, 7, lat, cd, bxd, byd, nd, nbx, nby, cp, cl, bb);
    total++; if (nd !== 1) $display("FAIL busy_tick_done_count got %0d want 1", nd); else passed++;
    total++; if (lat !== 16) $display("FAIL busy_tick_latency got %0d want 16", lat); else passed++;
    total++; if (bb !== 0) $display("FAIL busy_tick_busy got %0d bad cycles want 0", bb); else passed++;
    total++; if (cd !== 15'h0001 || bxd !== 1'b1 || byd !== 1'b0) $display("FAIL busy_tick_result got %h x%b y%b want 0001 x1 y0", cd, bxd, byd); else passed++;
  endtask

  task automatic test_midscan_reset();
    int lat, nd, nbx, nby, bb, ndone;
    logic [14:0] cd, cp, cl;
    logic bxd, byd;
    do_scan(80, 55, 15'h7FFF, -1, lat, cd, bxd, byd, nd, nbx, nby, cp, cl, bb);
    @(negedge clk);
    bus_if.ball_x = 10'd80; bus_if.ball_y = 10'd55; bus_if.alive = 15'h7FFF;
    bus_if.frame_tick = 1'b1;
    @(negedge clk);
    bus_if.frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus_if.collide !== 15'h0 || bus_if.busy !== 1'b0) $display("FAIL midrst_outputs collide %h busy %b want 0 0", bus_if.collide, bus_if.busy); else passed++;
    total++; if (bus_if.done !== 1'b0 || bus_if.bounce_x !== 1'b0 || bus_if.bounce_y !== 1'b0) $display("FAIL midrst_pulses got %b%b%b want 000", bus_if.done, bus_if.bounce_x, bus_if.bounce_y); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus_if.done === 1'b1) ndone++;
      @(negedge clk);
    end
    total++; if (ndone !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", ndone); else passed++;
    do_scan(136, 45, 15'h7FFF, -1, lat, cd, bxd, byd, nd, nbx, nby, cp, cl, bb);
    total++; if (lat !== 16 || cd !== 15'h0001 || bxd !== 1'b1 || byd !== 1'b0) $display("FAIL midrst_rescan got lat %0d col %h x%b y%b want 16 0001 x1 y0", lat, cd, bxd, byd); else passed++;
  endtask

  task automatic test_random();
    int lat, nd, nbx, nby, bb, bx, by;
    logic [14:0] cd, cp, cl, al, ecol;
    logic bxd, byd, ex, ey;
    for (int n = 0; n < 30; n++) begin
      if (n == 0) begin bx = 1020; by = 1019; end
      else begin bx = $urandom_range(20, 640); by = $urandom_range(20, 150); end
      al = (n % 2 == 0) ? 15'h7FFF : 15'($urandom());
      ref_scan(bx, by, al, ecol, ex, ey);
      do_scan(bx, by, al, -1, lat, cd, bxd, byd, nd, nbx, nby, cp, cl, bb);
      total++; if (cd !== ecol) $display("FAIL rnd%0d_collide ball (%0d,%0d) alive %h got %h want %h", n, bx, by, al, cd, ecol); else passed++;
      total++; if (bxd !== ex || byd !== ey) $display("FAIL rnd%0d_bounce ball (%0d,%0d) got x%b y%b want x%b y%b", n, bx, by, bxd, byd, ex, ey); else passed++;
      total++; if (lat !== 16 || nd !== 1) $display("FAIL rnd%0d_done got lat %0d pulses %0d want 16 1", n, lat, nd); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_alive_mask();
    test_tick_while_busy();
    test_midscan_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/brick_collide_scan.md
Name: brick_collide_scan

Overview:
- Produces the per-brick collision signals that the brick life tracker consumes, and consumes that tracker's alive flags in return.
- On each frame tick, latches the ball position and the 15 alive flags, then scans the 3x5 brick grid at one brick per cycle.
- Reports which live bricks the ball box overlaps, plus which velocity axis the ball controller must reflect.

Parameters:
- X0, 40, x of brick column 0 left edge (pixels)
- Y0, 40, y of brick row 0 top edge
- BRICK_W, 100, brick width
- BRICK_H, 20, brick height
- GAP_X, 12, horizontal gap between columns
- GAP_Y, 10, vertical gap between rows
- BALL, 8, ball square side length

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse requesting a scan
- ball_x  in  10  ball box left edge
- ball_y  in  10  ball box top edge
- alive  in  15  brick alive flags; bit i = brick i
- collide  out  15  per-brick hit flags for the last completed scan
- bounce_x  out  1  one-cycle pulse: negate x velocity
- bounce_y  out  1  one-cycle pulse: negate y velocity
- done  out  1  one-cycle pulse: scan complete, outputs updated
- busy  out  1  high while in SCAN or REPORT

Behaviour:
- Reset (async, rst=1): state IDLE; collide=0, bounce_x=0, bounce_y=0, done=0, busy=0; index and all latches cleared. Asserting reset mid-scan aborts the scan with no report.
- Brick indexing: index i = 5*row + col, with row 0..2 and col 0..4.
  - Brick left edge = X0 + col*(BRICK_W+GAP_X); top edge = Y0 + row*(BRICK_H+GAP_Y).
  - Generate these with col/row counters and running adders; no divider or multiplier.
- FSM states: IDLE, SCAN, REPORT.
- IDLE:
  - On frame_tick=1 at an edge, latch ball_x, ball_y and alive, clear the hit accumulator, set idx=0, go to SCAN.
- SCAN (15 cycles, idx 0..14):
  - ox = min(bx+BALL, brx+BRICK_W) - max(bx, brx); oy is the same for y.
  - Compute in 11-bit signed arithmetic; overlap counts only if ox>0 and oy>0 (edge touch is no hit).
  - Hit when overlap and latched alive[idx]=1.
  - On the first hit of the scan (lowest idx), record the axis:
    - ox<oy: x axis;
    - oy<ox: y axis;
    - equal: both axes.
  - Later hits set their collide bit only.
  - After idx=14, go to REPORT.
- REPORT (1 cycle):
  - On exit, drive collide=accumulator, done=1, and bounce_x/bounce_y per the recorded axis (both 0 if no hit).
  - Return to IDLE.
- Latency: tick sampled at edge T; done, collide and bounce are valid in the cycle after edge T+16.
- Output hold rules:
  - done, bounce_x and bounce_y are high for exactly one cycle.
  - collide holds its value until the next REPORT, so the life tracker's sampling window cannot miss it.
- frame_tick while busy=1: ignored. No queuing, no error flag.
- ball_x, ball_y and alive changing mid-scan have no effect; only the latched copies are used.
- Coordinates are unsigned 10-bit; ball_x+BALL may exceed 1023 and is handled in 11 bits without wrap.

Test Plan:
- Reset then tick with ball (80,55), alive=15'h7FFF -> brick 0: ox=8, oy=5; done pulses 16 cycles after tick; collide=15'h0001; bounce_y=1 for 1 cycle; bounce_x=0.
- Tick with ball (136,45), all alive -> ox=4, oy=8; collide=15'h0001; bounce_x=1; bounce_y=0.
- Tick with ball (136,56) -> ox=oy=4; collide=15'h0001; bounce_x=1 and bounce_y=1 on the same cycle.
- Ball (142,45) in the column gap, and ball (132,60) touching brick 0's bottom edge -> collide=0, done pulses, no bounce.
- alive=15'h7FFE with ball (80,55) -> collide=0, no bounce; the previous collide value is replaced by 0 at this scan's REPORT.
- Second frame_tick at idx=7 -> ignored, exactly one done pulse.
- rst=1 at idx=5 -> all outputs 0 immediately and no done; the next tick scans normally.
